instr_memory: RTL and testbench
===============================

Name: instr_memory

Overview:
- Responder end of the fetch memory interface: the instruction memory that answers `read_enable`/`memory_address` requests with `memory_value`.
- Word-organised RAM with a configurable-latency, fully pipelined read path.
- A program-load write port with byte masks is used by the testbench/boot loader.
- Address checking returns a safe NOP and a fault flag for bad fetches.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- BASE_ADDRESS, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- READ_LATENCY, 1, cycles from request accept to response; legal range 1..4.
- FAULT_VALUE, 32'h0000_0013, word returned on a faulting read (addi x0,x0,0).

Ports:
- clock  input  1  single clock, all state rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- read_enable  input  1  read request strobe from fetch; one request per cycle when high.
- memory_address  input  32  byte address of the requested instruction.
- memory_value  output  32  read data.
- value_valid  output  1  memory_value/access_fault carry a response this cycle.
- access_fault  output  1  the current response is a faulted read.
- load_enable  input  1  program-load write strobe.
- load_address  input  32  byte address of the word to write.
- load_data  input  32  write data.
- load_byte_mask  input  4  per-byte write enable; bit i writes bits [8i+7:8i].

Behaviour:
- **Reset.** Reset is asynchronous and active-low on reset_n, clocked by clock.
  - While reset_n=0: memory_value=0, value_valid=0, access_fault=0, and the read pipeline is flushed.
  - RAM contents are not reset and are preserved across reset.
- **Request accept.**
  - A request is accepted on every rising edge with read_enable=1 and reset_n=1.
  - There is no backpressure; the block never stalls.
- **Fault check at accept.**
  - Fault if memory_address[1:0] != 0.
  - Fault if memory_address < BASE_ADDRESS or memory_address >= BASE_ADDRESS + 4*DEPTH_WORDS.
  - A faulting read never indexes the array.
- **Latency.** A request accepted at edge N produces value_valid=1 in the cycle after edge N+READ_LATENCY-1.
  - READ_LATENCY=1: response is registered at the accepting edge and visible the following cycle.
  - Responses emerge strictly in request order, one per accepted request, and back-to-back requests give back-to-back responses.
- **Response content.**
  - Non-faulted read: array word, access_fault=0.
  - Faulted read: FAULT_VALUE, access_fault=1.
- **Idle.** In cycles with value_valid=0, memory_value holds its last value and access_fault=0.
- **Load.**
  - On an edge with load_enable=1, a word-aligned, in-range load_address writes the masked bytes.
  - A misaligned or out-of-range load is silently dropped.
  - load_byte_mask=0 performs no write.
- **Simultaneous load and read to the same word.** Write-first: the read returns the merged new word (new bytes where masked, old bytes elsewhere).
- **Simultaneous load and read to different words.** Both proceed independently.
- **Reset mid-operation.** In-flight requests are discarded and produce no response after reset_n rises. A load coincident with reset assertion is not guaranteed to complete.
- **Address indexing.** Word index = (memory_address - BASE_ADDRESS) >> 2, using log2(DEPTH_WORDS) bits.

Decomposition:
- **Shared package riscv_mem_pkg:**
  - XLEN=32, WORD_BYTES=4.
  - NOP_INSTR=32'h0000_0013.
  - A word type.
  - An address-check helper function returning {aligned, in_range}.
- **Sub-module imem_read_pipe.** Parameterised delay line of READ_LATENCY stages carrying {valid, fault, data}. It is flushed by reset_n. The top level owns the RAM array, the load path with write-first merge, and the fault checks.

Test Plan:
- **Basic load then read.** Reset, release; load 0x00500093 at 0x0 with mask 4'hF; read 0x0 at READ_LATENCY=1 -> next cycle value_valid=1, memory_value=0x00500093, access_fault=0.
- **Pipelined reads.** READ_LATENCY=3; words 0x11111111/0x22222222/0x33333333 loaded at 0x0/0x4/0x8; reads issued on three consecutive edges -> three consecutive valid responses in that order, first appearing 3 cycles after the first request.
- **Misaligned read.** Read 0x00000002 -> value_valid=1, memory_value=0x00000013, access_fault=1. An out-of-range read at 0x00001000 (DEPTH_WORDS=1024) gives the same response, and the array is unchanged.
- **Write-first merge.** Word 0x10 holds 0x11223344; same edge: load 0xDEADBEEF mask 4'b0011 at 0x10 and read 0x10 -> response 0x1122BEEF. A later read also returns 0x1122BEEF.
- **Dropped loads.** Load to 0x00001000 and to 0x5 with mask 4'hF -> reading 0x0..0xC afterwards shows no change.
- **Reset with reads in flight.** READ_LATENCY=3; two reads in flight; reset_n=0 asynchronously mid-cycle -> value_valid=0 and memory_value=0 immediately. After release: no stale responses, and earlier loaded words still read back correctly.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared word type, response record and address-check helper for the
// RISC-V memory slice.
package riscv_mem_pkg;

    localparam int XLEN       = 32;
    localparam int WORD_BYTES = 4;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic  valid;
        logic  fault;
        word_t data;
    } rsp_t;

    // Returns {aligned, in_range}; the offset form avoids overflow when the
    // window ends at the top of the address space.
    function automatic logic [1:0] addr_check(input word_t addr, input word_t base,
                                               input int unsigned depth_words);
        word_t offset;
        logic  aligned;
        logic  in_range;
        offset   = addr - base;
        aligned  = (addr[1:0] == 2'b00);
        in_range = (addr >= base) && ((offset >> 2) < word_t'(depth_words));
        return {aligned, in_range};
    endfunction

endpackage

// File: rtl/instr_memory_if.sv
// Fetch-side bus between the fetch unit (master) and the instruction memory
// (slave).
interface instr_memory_if;
    import riscv_mem_pkg::*;

    // read_enable is a strobe with no ready: every cycle it is high is one
    // accepted request. value_valid marks one response per request, in order.
    logic  read_enable;
    word_t memory_address;
    word_t memory_value;
    logic  value_valid;
    logic  access_fault;

    modport master (
        output read_enable, memory_address,
        input  memory_value, value_valid, access_fault
    );

    modport slave (
        input  read_enable, memory_address,
        output memory_value, value_valid, access_fault
    );

endinterface

// File: rtl/imem_read_pipe.sv
// Delay line of LATENCY stages carrying {valid, fault, data}; data only
// advances with a valid entry, so the last stage holds the last response.
module imem_read_pipe
    import riscv_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  rsp_t in_rsp,
    output rsp_t out_rsp
);

    rsp_t stage_q [LATENCY];
    rsp_t stage_d [LATENCY];

    always_comb begin
        stage_d[0].valid = in_rsp.valid;
        stage_d[0].fault = in_rsp.valid & in_rsp.fault;
        stage_d[0].data  = in_rsp.valid ? in_rsp.data : stage_q[0].data;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i].valid = stage_q[i-1].valid;
            stage_d[i].fault = stage_q[i-1].fault;
            stage_d[i].data  = stage_q[i-1].valid ? stage_q[i-1].data : stage_q[i].data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign out_rsp = stage_q[LATENCY-1];

endmodule

// File: rtl/instr_memory.sv
// Instruction memory: word RAM with byte-masked program-load port, address
// fault checking and a fully pipelined read path of READ_LATENCY cycles.
module instr_memory
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter word_t       BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1,
    parameter word_t       FAULT_VALUE  = NOP_INSTR
) (
    input  logic                  clock,
    input  logic                  reset_n,
    instr_memory_if.slave         fetch,
    input  logic                  load_enable,
    input  word_t                 load_address,
    input  word_t                 load_data,
    input  logic [WORD_BYTES-1:0] load_byte_mask
);

    localparam int AW = $clog2(DEPTH_WORDS);

    word_t         mem_q [DEPTH_WORDS];
    word_t         mem_wr_d;
    logic [1:0]    rd_chk;
    logic [1:0]    ld_chk;
    logic          rd_fault;
    logic          ld_we;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] ld_idx;
    word_t         rd_data;
    rsp_t          pipe_in;
    rsp_t          pipe_out;

    always_comb begin
        rd_chk   = addr_check(fetch.memory_address, BASE_ADDRESS, DEPTH_WORDS);
        ld_chk   = addr_check(load_address, BASE_ADDRESS, DEPTH_WORDS);
        rd_fault = ~&rd_chk;
        ld_we    = load_enable && (&ld_chk) && (|load_byte_mask);
        // A faulting fetch is steered to word 0 and its data discarded below.
        rd_idx   = rd_fault ? '0 : AW'((fetch.memory_address - BASE_ADDRESS) >> 2);
        ld_idx   = AW'((load_address - BASE_ADDRESS) >> 2);

        mem_wr_d = mem_q[ld_idx];
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (load_byte_mask[b]) mem_wr_d[8*b +: 8] = load_data[8*b +: 8];
        end

        // Write-first: a same-edge load to the fetched word is forwarded.
        if (rd_fault)                         rd_data = FAULT_VALUE;
        else if (ld_we && (ld_idx == rd_idx)) rd_data = mem_wr_d;
        else                                  rd_data = mem_q[rd_idx];

        pipe_in.valid = fetch.read_enable;
        pipe_in.fault = rd_fault;
        pipe_in.data  = rd_data;
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (ld_we) mem_q[ld_idx] <= mem_wr_d;
    end

    imem_read_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .in_rsp  (pipe_in),
        .out_rsp (pipe_out)
    );

    assign fetch.memory_value = pipe_out.data;
    assign fetch.value_valid  = pipe_out.valid;
    assign fetch.access_fault = pipe_out.valid & pipe_out.fault;

endmodule

// File: tb/tb_instr_memory.sv
// Bench for instr_memory: two instances (READ_LATENCY 1 and 3) share stimulus;
// a reference word model feeds per-instance expected queues.
module tb_instr_memory;
    import riscv_mem_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam word_t       NOP   = 32'h0000_0013;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  load_enable = 1'b0;
    word_t                 load_address = '0;
    word_t                 load_data = '0;
    logic [WORD_BYTES-1:0] load_byte_mask = '0;
    int unsigned           cyc = 0;

    instr_memory_if if_l1 ();
    instr_memory_if if_l3 ();

    instr_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(32'h0), .READ_LATENCY(1), .FAULT_VALUE(NOP)) u_dut_l1 (
        .clock (clock), .reset_n (reset_n), .fetch (if_l1.slave),
        .load_enable (load_enable), .load_address (load_address),
        .load_data (load_data), .load_byte_mask (load_byte_mask)
    );

    instr_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(32'h0), .READ_LATENCY(3), .FAULT_VALUE(NOP)) u_dut_l3 (
        .clock (clock), .reset_n (reset_n), .fetch (if_l3.slave),
        .load_enable (load_enable), .load_address (load_address),
        .load_data (load_data), .load_byte_mask (load_byte_mask)
    );

    // Clock/reset and cycle count
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard state: entry = {expected cycle, fault, data}
    word_t       model_mem [DEPTH];
    logic [64:0] exp_q1[$];
    logic [64:0] exp_q3[$];
    word_t       last_val [2];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input word_t ra, input logic ld, input word_t la,
                         input word_t ldat, input logic [3:0] lm);
        logic  f;
        word_t d;
        @(posedge clock);
        #1;
        if_l1.read_enable = rd;  if_l1.memory_address = ra;
        if_l3.read_enable = rd;  if_l3.memory_address = ra;
        load_enable = ld; load_address = la; load_data = ldat; load_byte_mask = lm;
        if (ld && la[1:0] == 2'b00 && la < DEPTH * 4) begin
            for (int b = 0; b < 4; b++)
                if (lm[b]) model_mem[la >> 2][8*b +: 8] = ldat[8*b +: 8];
        end
        if (rd) begin
            f = (ra[1:0] != 2'b00) || (ra >= DEPTH * 4);
            d = f ? NOP : model_mem[ra >> 2];
            exp_q1.push_back({cyc + 32'd1, f, d});
            exp_q3.push_back({cyc + 32'd3, f, d});
        end
    endtask

    task automatic rd(input word_t a);
        drive(1'b1, a, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic ld(input word_t a, input word_t dat, input logic [3:0] m);
        drive(1'b0, '0, 1'b1, a, dat, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic monitor(input int idx, input logic v, input logic f, input word_t d);
        logic [64:0] e;
        string       nm;
        int          qsz;
        nm  = (idx == 0) ? "l1" : "l3";
        qsz = (idx == 0) ? exp_q1.size() : exp_q3.size();
        if (v) begin
            if (qsz == 0) begin
                check({nm, "_unexpected_rsp"}, 64'(v), 64'd0);
            end else begin
                if (idx == 0) e = exp_q1.pop_front();
                else          e = exp_q3.pop_front();
                check({nm, "_data"},  64'(d),   64'(e[31:0]));
                check({nm, "_fault"}, 64'(f),   64'(e[32]));
                check({nm, "_cycle"}, 64'(cyc), 64'(e[64:33]));
                last_val[idx] = e[31:0];
            end
        end else begin
            check({nm, "_idle_fault"}, 64'(f), 64'd0);
            check({nm, "_idle_hold"},  64'(d), 64'(last_val[idx]));
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            monitor(0, if_l1.value_valid, if_l1.access_fault, if_l1.memory_value);
            monitor(1, if_l3.value_valid, if_l3.access_fault, if_l3.memory_value);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_l1_valid"}, 64'(if_l1.value_valid),  64'd0);
        check({tag, "_l1_value"}, 64'(if_l1.memory_value), 64'd0);
        check({tag, "_l1_fault"}, 64'(if_l1.access_fault), 64'd0);
        check({tag, "_l3_valid"}, 64'(if_l3.value_valid),  64'd0);
        check({tag, "_l3_value"}, 64'(if_l3.memory_value), 64'd0);
        check({tag, "_l3_fault"}, 64'(if_l3.access_fault), 64'd0);
    endtask

    initial begin
        if_l1.read_enable = 1'b0; if_l1.memory_address = '0;
        if_l3.read_enable = 1'b0; if_l3.memory_address = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        last_val[0] = '0;
        last_val[1] = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #3;
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Basic load then read
        ld(32'h0, 32'h0050_0093, 4'hF);
        rd(32'h0);
        idle(4);

        // Pipelined back-to-back reads
        ld(32'h0, 32'h1111_1111, 4'hF);
        ld(32'h4, 32'h2222_2222, 4'hF);
        ld(32'h8, 32'h3333_3333, 4'hF);
        ld(32'hC, 32'h4444_4444, 4'hF);
        rd(32'h0);
        rd(32'h4);
        rd(32'h8);
        idle(4);

        // Misaligned and out-of-range fetches, then array unchanged
        rd(32'h0000_0002);
        rd(32'h0000_1000);
        rd(32'hFFFF_FFFC);
        for (int a = 0; a < 16; a += 4) rd(word_t'(a));
        idle(4);

        // Write-first merge on the same edge
        ld(32'h10, 32'h1122_3344, 4'hF);
        drive(1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
        idle(2);
        rd(32'h10);
        idle(4);

        // Dropped loads: out of range, misaligned, empty mask
        ld(32'h0000_1000, 32'hBAD0_BAD0, 4'hF);
        ld(32'h0000_0005, 32'hBAD1_BAD1, 4'hF);
        ld(32'h0000_0000, 32'hBAD2_BAD2, 4'h0);
        for (int a = 0; a < 16; a += 4) rd(word_t'(a));
        idle(4);

        // Simultaneous load and read to different words
        drive(1'b1, 32'h4, 1'b1, 32'h8, 32'hCAFE_F00D, 4'b1100);
        rd(32'h8);
        idle(4);

        // Randomised mix over a preloaded window
        for (int a = 0; a < 64; a += 4) ld(word_t'(a), $urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            logic  r, l;
            word_t ra;
            int    sel;
            r   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 8)       ra = $urandom_range(0, 15) * 4;
            else if (sel == 8) ra = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
            else               ra = 32'h1000 + $urandom_range(0, 255) * 4;
            drive(r, ra, l, $urandom_range(0, 15) * 4, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(4);

        // Reset with reads in flight
        rd(32'h0);
        rd(32'h4);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        if_l1.read_enable = 1'b0;
        if_l3.read_enable = 1'b0;
        load_enable = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q1.delete();
        exp_q3.delete();
        last_val[0] = '0;
        last_val[1] = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(5);
        for (int a = 0; a < 64; a += 4) rd(word_t'(a));

        // Drain: every expected response must have emerged
        idle(6);
        check("l1_drain", 64'(exp_q1.size()), 64'd0);
        check("l3_drain", 64'(exp_q3.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
